// File: rtl/ttl_pkg.sv
// Shared definitions for the TTL pin-level models.
// Pin bundle layout and load/shift encodings.
package ttl_pkg;

  localparam int TTL_SHIFT_W = 8;

  typedef enum logic {
    LD = 1'b0,
    SH = 1'b1
  } sh_ld_e;

  typedef struct packed {
    logic                   sh_ld;
    logic                   clk_inh;
    logic                   clk_pin;
    logic                   ser;
    logic [TTL_SHIFT_W-1:0] par;
  } ttl_165_pins_t;

  localparam int TTL_165_PIN_W = $bits(ttl_165_pins_t);

  function automatic logic gate_clk(
    input logic c,
    input logic inh
  );
    return c | inh;
  endfunction

endpackage

// File: rtl/ttl_edge_detect.sv
// Optional pin synchronizer plus rising-edge detector.
// Prev flop resets high so a gate already high is not an edge.
module ttl_edge_detect #(
  parameter int SYNC_STAGES = 0,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] pins,
  output logic [W-1:0] pins_s,
  input  logic         gate,
  output logic         rise
);

  logic gprev;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign pins_s = pins;
  end else begin : g_sync
    logic [W-1:0] sync_q [SYNC_STAGES];

    // Shift pins through the synchronizer chain.
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < SYNC_STAGES; i++) begin
          sync_q[i] <= '0;
        end
      end else begin
        sync_q[0] <= pins;
        for (int i = 1; i < SYNC_STAGES; i++) begin
          sync_q[i] <= sync_q[i-1];
        end
      end
    end

    assign pins_s = sync_q[SYNC_STAGES-1];
  end

  // Remember last gate level; tracked every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      gprev <= 1'b1;
    end else begin
      gprev <= gate;
    end
  end

  assign rise = gate & ~gprev;

endmodule

// File: rtl/ttl_74165.sv
// 74165 parallel-in/serial-out shift register.
// Pins sampled on clk; shifts on rising edges of CLK|CLK_INH.
module ttl_74165
  import ttl_pkg::*;
#(
  parameter int SYNC_STAGES = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic _A,
  input  logic _B,
  input  logic _C,
  input  logic _D,
  input  logic _E,
  input  logic _F,
  input  logic _G,
  input  logic _H,
  input  logic SER,
  input  logic CLK,
  input  logic CLK_INH,
  input  logic SH_LD,
  output logic QH,
  output logic QH_n
);

  ttl_165_pins_t pins_raw;
  ttl_165_pins_t pins_s;

  logic [TTL_SHIFT_W-1:0] q;
  logic [TTL_SHIFT_W-1:0] q_nxt;
  logic                   qh_n_q;
  logic                   g;
  logic                   rise;
  logic                   do_load;
  logic                   do_shift;

  assign pins_raw = {SH_LD, CLK_INH, CLK, SER,
                     _H, _G, _F, _E, _D, _C, _B, _A};

  ttl_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES),
    .W           (TTL_165_PIN_W)
  ) u_edge (
    .clk    (clk),
    .reset  (reset),
    .pins   (pins_raw),
    .pins_s (pins_s),
    .gate   (g),
    .rise   (rise)
  );

  assign g = gate_clk(pins_s.clk_pin, pins_s.clk_inh);

  assign do_load  = (sh_ld_e'(pins_s.sh_ld) == LD);
  assign do_shift = ~do_load & rise;

  // Load is level-sensitive and beats a coincident edge.
  always_comb begin
    q_nxt = q;
    unique case (1'b1)
      do_load:  q_nxt = pins_s.par;
      do_shift: q_nxt = {q[TTL_SHIFT_W-2:0], pins_s.ser};
      default:  q_nxt = q;
    endcase
  end

  // Shift register plus a registered complement output.
  always_ff @(posedge clk) begin
    if (reset) begin
      q      <= '0;
      qh_n_q <= 1'b1;
    end else begin
      q      <= q_nxt;
      qh_n_q <= ~q_nxt[TTL_SHIFT_W-1];
    end
  end

  assign QH   = q[TTL_SHIFT_W-1];
  assign QH_n = qh_n_q;

endmodule

// File: tb/tb_ttl_74165.sv
// Directed bench for ttl_74165.
// Checks unsynchronized and two-stage synchronized builds.
module tb_ttl_74165;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] par = 8'h00;
  logic       ser = 1'b0;
  logic       ck = 1'b0;
  logic       inh = 1'b0;
  logic       shld = 1'b1;
  logic       qh0, qhn0, qh2, qhn2;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  ttl_74165 #(.SYNC_STAGES(0)) dut0 (
    .clk(clk), .reset(reset),
    ._A(par[0]), ._B(par[1]), ._C(par[2]), ._D(par[3]),
    ._E(par[4]), ._F(par[5]), ._G(par[6]), ._H(par[7]),
    .SER(ser), .CLK(ck), .CLK_INH(inh), .SH_LD(shld),
    .QH(qh0), .QH_n(qhn0)
  );

  ttl_74165 #(.SYNC_STAGES(2)) dut2 (
    .clk(clk), .reset(reset),
    ._A(par[0]), ._B(par[1]), ._C(par[2]), ._D(par[3]),
    ._E(par[4]), ._F(par[5]), ._G(par[6]), ._H(par[7]),
    .SER(ser), .CLK(ck), .CLK_INH(inh), .SH_LD(shld),
    .QH(qh2), .QH_n(qhn2)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    checks++;
    if (qh0 !== 1'b0) begin
      errors++; $display("FAIL reset_qh0 got %b expected 0", qh0);
    end
    checks++;
    if (qhn0 !== 1'b1) begin
      errors++; $display("FAIL reset_qhn0 got %b expected 1", qhn0);
    end
    checks++;
    if (qh2 !== 1'b0) begin
      errors++; $display("FAIL reset_qh2 got %b expected 0", qh2);
    end
    checks++;
    if (qhn2 !== 1'b1) begin
      errors++; $display("FAIL reset_qhn2 got %b expected 1", qhn2);
    end
  endtask

  task automatic test_load_shift;
    logic [7:0] pat;
    logic       e;
    pat  = 8'b01001010;
    par  = 8'b10100101;
    shld = 1'b0;
    tick(2);
    checks++;
    if (qh0 !== 1'b1) begin
      errors++; $display("FAIL load_qh got %b expected 1", qh0);
    end
    checks++;
    if (qhn0 !== 1'b0) begin
      errors++; $display("FAIL load_qhn got %b expected 0", qhn0);
    end
    shld = 1'b1;
    tick(1);
    for (int i = 0; i < 8; i++) begin
      e  = pat[7-i];
      ck = 1'b1;
      tick(2);
      checks++;
      if (qh0 !== e) begin
        errors++;
        $display("FAIL shift_qh pulse %0d got %b expected %b", i+1, qh0, e);
      end
      checks++;
      if (qhn0 !== ~e) begin
        errors++;
        $display("FAIL shift_qhn pulse %0d got %b expected %b", i+1, qhn0, ~e);
      end
      ck = 1'b0;
      tick(2);
    end
  endtask

  task automatic test_cascade;
    logic e;
    par  = 8'h00;
    shld = 1'b0;
    tick(2);
    shld = 1'b1;
    ser  = 1'b1;
    tick(1);
    for (int i = 1; i <= 8; i++) begin
      e  = (i == 8);
      ck = 1'b1;
      tick(2);
      checks++;
      if (qh0 !== e) begin
        errors++;
        $display("FAIL cascade pulse %0d got %b expected %b", i, qh0, e);
      end
      ck = 1'b0;
      tick(2);
    end
    ser = 1'b0;
  endtask

  task automatic test_inhibit;
    par  = 8'b10100000;
    ck   = 1'b0;
    inh  = 1'b1;
    shld = 1'b0;
    tick(2);
    shld = 1'b1;
    tick(1);
    for (int i = 0; i < 4; i++) begin
      ck = 1'b1;
      tick(2);
      checks++;
      if (qh0 !== 1'b1) begin
        errors++; $display("FAIL inhibit_hi %0d got %b expected 1", i, qh0);
      end
      ck = 1'b0;
      tick(2);
      checks++;
      if (qh0 !== 1'b1) begin
        errors++; $display("FAIL inhibit_lo %0d got %b expected 1", i, qh0);
      end
    end
    inh = 1'b0;
    tick(2);
    checks++;
    if (qh0 !== 1'b1) begin
      errors++; $display("FAIL inh_fall got %b expected 1", qh0);
    end
    inh = 1'b1;
    tick(2);
    checks++;
    if (qh0 !== 1'b0) begin
      errors++; $display("FAIL inh_rise got %b expected 0", qh0);
    end
    tick(4);
    checks++;
    if (qh0 !== 1'b0) begin
      errors++; $display("FAIL inh_once got %b expected 0", qh0);
    end
    inh = 1'b0;
    tick(2);
  endtask

  task automatic test_reset_clk_high;
    logic e;
    ser = 1'b1;
    ck  = 1'b1;
    tick(2);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    checks++;
    if (qh0 !== 1'b0) begin
      errors++; $display("FAIL rst_hi_qh got %b expected 0", qh0);
    end
    checks++;
    if (qhn0 !== 1'b1) begin
      errors++; $display("FAIL rst_hi_qhn got %b expected 1", qhn0);
    end
    tick(3);
    ck = 1'b0;
    tick(2);
    for (int i = 1; i <= 8; i++) begin
      e  = (i == 8);
      ck = 1'b1;
      tick(2);
      checks++;
      if (qh0 !== e) begin
        errors++;
        $display("FAIL rst_hi_count pulse %0d got %b expected %b", i, qh0, e);
      end
      ck = 1'b0;
      tick(2);
    end
    ser = 1'b0;
  endtask

  task automatic test_simul;
    ck   = 1'b0;
    par  = 8'b01000000;
    shld = 1'b0;
    tick(2);
    checks++;
    if (qh0 !== 1'b0) begin
      errors++; $display("FAIL simul_load got %b expected 0", qh0);
    end
    shld = 1'b1;
    ck   = 1'b1;
    tick(1);
    checks++;
    if (qh0 !== 1'b1) begin
      errors++; $display("FAIL simul_shift got %b expected 1", qh0);
    end
    ck = 1'b0;
    tick(2);
    par  = 8'b10000000;
    shld = 1'b0;
    ck   = 1'b1;
    tick(1);
    checks++;
    if (qh0 !== 1'b1) begin
      errors++; $display("FAIL simul_ldwins got %b expected 1", qh0);
    end
    shld = 1'b1;
    tick(2);
    checks++;
    if (qh0 !== 1'b1) begin
      errors++; $display("FAIL shld_rise_ghigh got %b expected 1", qh0);
    end
    ck = 1'b0;
    tick(2);
    ck = 1'b1;
    tick(1);
    checks++;
    if (qh0 !== 1'b0) begin
      errors++; $display("FAIL simul_reedge got %b expected 0", qh0);
    end
    ck = 1'b0;
    tick(2);
  endtask

  task automatic test_sync2;
    logic [7:0] pat;
    logic       e;
    logic       prev;
    pat  = 8'b01001010;
    ck   = 1'b0;
    inh  = 1'b0;
    ser  = 1'b0;
    par  = 8'b10100101;
    shld = 1'b0;
    tick(4);
    checks++;
    if (qh2 !== 1'b1) begin
      errors++; $display("FAIL sync2_load got %b expected 1", qh2);
    end
    checks++;
    if (qhn2 !== 1'b0) begin
      errors++; $display("FAIL sync2_load_n got %b expected 0", qhn2);
    end
    shld = 1'b1;
    tick(4);
    prev = 1'b1;
    for (int i = 0; i < 8; i++) begin
      e  = pat[7-i];
      ck = 1'b1;
      tick(2);
      checks++;
      if (qh2 !== prev) begin
        errors++;
        $display("FAIL sync2_early pulse %0d got %b expected %b", i+1, qh2, prev);
      end
      tick(1);
      checks++;
      if (qh2 !== e) begin
        errors++;
        $display("FAIL sync2_lat3 pulse %0d got %b expected %b", i+1, qh2, e);
      end
      ck = 1'b0;
      tick(3);
      prev = e;
    end
  endtask

  initial begin
    test_reset();
    test_load_shift();
    test_cascade();
    test_inhibit();
    test_reset_clk_high();
    test_simul();
    test_sync2();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
